// File: rtl/idli_pkg.sv
// Shared types and constants for the SQI serial-SRAM responder.
// Build macro IDLI_SQI_MEM_WR_EN enables the write command and array write port.
package idli_pkg;

  typedef enum logic [2:0] {
    IDLI_SQI_ST_IDLE,
    IDLI_SQI_ST_CMD,
    IDLI_SQI_ST_ADDR,
    IDLI_SQI_ST_DUMMY,
    IDLI_SQI_ST_RD,
    IDLI_SQI_ST_WR,
    IDLI_SQI_ST_ERR
  } idli_pkg_sqi_mem_state_t;

  localparam logic [7:0] IDLI_SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] IDLI_SQI_CMD_WRITE = 8'h02;
  localparam int         IDLI_SQI_ADDR_NIB  = 6;

`ifdef IDLI_SQI_MEM_WR_EN
  localparam bit IDLI_SQI_WR_EN = 1'b1;
`else
  localparam bit IDLI_SQI_WR_EN = 1'b0;
`endif

endpackage

// File: rtl/idli_sqi_mem_array_m.sv
// Byte storage: one synchronous write port, one asynchronous read port.
// Write port exists only when IDLI_SQI_MEM_WR_EN is defined; otherwise reads return zero.
module idli_sqi_mem_array_m #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

`ifdef IDLI_SQI_MEM_WR_EN
  logic [7:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
`else
  // Read-only build: contents are the all-zero initial image.
  logic unused_wr;
  assign unused_wr = ^{clk_i, we_i, waddr_i, wdata_i, raddr_i};
  assign rdata_o   = 8'h00;
`endif

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder: decodes cmd/addr/data nibbles and serves the byte array.
// Define IDLI_SQI_MEM_WR_EN to accept command 0x02 (write); otherwise the block is read-only.
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DUMMY_NIB = 2
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst_n,
  input  logic       i_mem_sqi_sck,
  input  logic       i_mem_sqi_cs,
  input  logic [3:0] i_mem_sqi_data,
  output logic [3:0] o_mem_sqi_data,
  output logic       o_mem_sqi_oe
);

  localparam int NIB_W = 8;

  idli_pkg_sqi_mem_state_t state_q, state_d;

  logic              sck_q, cs_q;
  logic [NIB_W-1:0]  nib_ctr_q, nib_ctr_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_wr_q, is_wr_d;
  logic              half_q, half_d;
  logic [3:0]        hi_q, hi_d;
  logic [3:0]        data_q, data_d;
  logic              oe_q, oe_d;
  logic              we;
  logic [7:0]        rdata;
  logic              rise, fall, cs_fall;
  logic [7:0]        cmd_full;

  // Edges are masked by cs so a simultaneous cs rise wins over the sck edge.
  assign rise     = ~sck_q &  i_mem_sqi_sck & ~i_mem_sqi_cs;
  assign fall     =  sck_q & ~i_mem_sqi_sck & ~i_mem_sqi_cs;
  assign cs_fall  =  cs_q  & ~i_mem_sqi_cs;
  assign cmd_full = {cmd_q, i_mem_sqi_data};

  idli_sqi_mem_array_m #(.ADDR_W(ADDR_W)) u_array (
    .clk_i   (i_mem_gck),
    .we_i    (we),
    .waddr_i (addr_q),
    .wdata_i ({hi_q, i_mem_sqi_data}),
    .raddr_i (addr_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) state_q <= IDLI_SQI_ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_mem_sqi_cs) begin
      state_d = IDLI_SQI_ST_IDLE;
    end else begin
      unique case (state_q)
        IDLI_SQI_ST_IDLE:
          if (cs_fall) state_d = IDLI_SQI_ST_CMD;
        IDLI_SQI_ST_CMD:
          if (rise && nib_ctr_q == NIB_W'(1)) begin
            if (cmd_full == IDLI_SQI_CMD_READ)                         state_d = IDLI_SQI_ST_ADDR;
            else if (cmd_full == IDLI_SQI_CMD_WRITE && IDLI_SQI_WR_EN) state_d = IDLI_SQI_ST_ADDR;
            else                                                       state_d = IDLI_SQI_ST_ERR;
          end
        IDLI_SQI_ST_ADDR:
          if (rise && nib_ctr_q == NIB_W'(IDLI_SQI_ADDR_NIB-1)) begin
            if (is_wr_q)             state_d = IDLI_SQI_ST_WR;
            else if (DUMMY_NIB == 0) state_d = IDLI_SQI_ST_RD;
            else                     state_d = IDLI_SQI_ST_DUMMY;
          end
        IDLI_SQI_ST_DUMMY:
          if (rise && nib_ctr_q == NIB_W'(DUMMY_NIB-1)) state_d = IDLI_SQI_ST_RD;
        default: ;
      endcase
    end
  end

  always_comb begin
    nib_ctr_d = nib_ctr_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    is_wr_d   = is_wr_q;
    half_d    = half_q;
    hi_d      = hi_q;
    data_d    = data_q;
    oe_d      = oe_q;
    we        = 1'b0;
    if (i_mem_sqi_cs) begin
      oe_d   = 1'b0;
      half_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLI_SQI_ST_IDLE:
          if (cs_fall) begin
            nib_ctr_d = '0;
            half_d    = 1'b0;
          end
        IDLI_SQI_ST_CMD:
          if (rise) begin
            cmd_d     = i_mem_sqi_data;
            nib_ctr_d = nib_ctr_q + NIB_W'(1);
            if (nib_ctr_q == NIB_W'(1)) begin
              nib_ctr_d = '0;
              is_wr_d   = (cmd_full == IDLI_SQI_CMD_WRITE);
            end
          end
        IDLI_SQI_ST_ADDR:
          if (rise) begin
            // Shifting through an ADDR_W register drops address bits above ADDR_W.
            addr_d    = ADDR_W'({addr_q, i_mem_sqi_data});
            nib_ctr_d = (nib_ctr_q == NIB_W'(IDLI_SQI_ADDR_NIB-1)) ? '0 : nib_ctr_q + NIB_W'(1);
          end
        IDLI_SQI_ST_DUMMY:
          if (rise) nib_ctr_d = nib_ctr_q + NIB_W'(1);
        IDLI_SQI_ST_RD:
          if (fall) begin
            oe_d   = 1'b1;
            data_d = half_q ? rdata[3:0] : rdata[7:4];
            half_d = ~half_q;
            if (half_q) addr_d = addr_q + ADDR_W'(1);
          end
        IDLI_SQI_ST_WR:
          if (rise) begin
            if (!half_q) begin
              hi_d   = i_mem_sqi_data;
              half_d = 1'b1;
            end else begin
              we     = 1'b1;
              addr_d = addr_q + ADDR_W'(1);
              half_d = 1'b0;
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      nib_ctr_q <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      half_q    <= 1'b0;
      hi_q      <= '0;
      data_q    <= '0;
      oe_q      <= 1'b0;
    end else begin
      sck_q     <= i_mem_sqi_sck;
      cs_q      <= i_mem_sqi_cs;
      nib_ctr_q <= nib_ctr_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      is_wr_q   <= is_wr_d;
      half_q    <= half_d;
      hi_q      <= hi_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
    end
  end

  assign o_mem_sqi_data = data_q;
  assign o_mem_sqi_oe   = oe_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Scoreboard bench for idli_sqi_mem_m: SQI master tasks push expected nibbles, monitor checks on sck rise.
module tb_idli_sqi_mem_m;

  localparam int ADDR_W    = 16;
  localparam int DUMMY_NIB = 2;
  localparam int AMASK     = (1 << ADDR_W) - 1;
`ifdef IDLI_SQI_MEM_WR_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic       gck   = 1'b0;
  logic       rst_n = 1'b1;
  logic       sck   = 1'b0;
  logic       cs    = 1'b1;
  logic [3:0] din   = 4'h0;
  logic [3:0] dout;
  logic       oe;

  int compared   = 0;
  int mismatched = 0;

  logic [4:0]   exp_q[$];
  logic [7:0]   model[int];
  int           wr_addr_q[$];
  int           wr_len_q[$];

  always #5 gck = ~gck;

  idli_sqi_mem_m #(.ADDR_W(ADDR_W), .DUMMY_NIB(DUMMY_NIB)) dut (
    .i_mem_gck      (gck),
    .i_mem_rst_n    (rst_n),
    .i_mem_sqi_sck  (sck),
    .i_mem_sqi_cs   (cs),
    .i_mem_sqi_data (din),
    .o_mem_sqi_data (dout),
    .o_mem_sqi_oe   (oe)
  );

  function automatic logic [7:0] mget(input int a);
    int k;
    k = a & AMASK;
    return model.exists(k) ? model[k] : 8'h00;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge gck);
  endtask

  // One nibble: data set while sck low, master samples and DUT captures on the rise.
  task automatic nib(input logic [3:0] n, input logic eoe, input logic [3:0] ed);
    exp_q.push_back({eoe, ed});
    sck = 1'b0;
    din = n;
    tick(2);
    sck = 1'b1;
    tick(2);
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    tick(2);
  endtask

  task automatic cs_end();
    cs = 1'b1;
    tick(1);
    sck = 1'b0;
    tick(2);
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
    nib(cmd[7:4], 1'b0, 4'h0);
    nib(cmd[3:0], 1'b0, 4'h0);
    for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4], 1'b0, 4'h0);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    int p;
    logic [7:0] b;
    p = int'(a) & AMASK;
    cs_begin();
    hdr(8'h03, a);
    repeat (DUMMY_NIB) nib(4'($urandom), 1'b0, 4'h0);
    for (int i = 0; i < n; i++) begin
      b = mget(p);
      nib(4'($urandom), 1'b1, b[7:4]);
      nib(4'($urandom), 1'b1, b[3:0]);
      p = (p + 1) & AMASK;
    end
    cs_end();
  endtask

  // Writes n bytes taken from the top of 'bytes'; without write support the DUT sits in ERR.
  task automatic do_write(input logic [23:0] a, input logic [31:0] bytes, input int n);
    int p;
    logic [7:0] b;
    p = int'(a) & AMASK;
    if (WR_EN) begin
      wr_addr_q.push_back(p);
      wr_len_q.push_back(n);
    end
    cs_begin();
    hdr(8'h02, a);
    for (int i = 0; i < n; i++) begin
      b = bytes[31-8*i -: 8];
      nib(b[7:4], 1'b0, 4'h0);
      nib(b[3:0], 1'b0, 4'h0);
      if (WR_EN) model[p] = b;
      p = (p + 1) & AMASK;
    end
    cs_end();
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge sck) begin
    logic [4:0] e;
    if (!cs && rst_n) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_nibble: got oe=%0b data=%h with nothing expected", oe, dout);
      end else begin
        e = exp_q.pop_front();
        if (oe !== e[4] || (e[4] && dout !== e[3:0])) begin
          mismatched++;
          $display("FAIL nibble @%0t: got oe=%0b data=%h expected oe=%0b data=%h",
                   $time, oe, dout, e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  b;
    logic [23:0] ra;
    logic [31:0] rb;
    int          k, n;

    #1 rst_n = 1'b0;
    tick(3);
    check("reset_oe", {7'd0, oe}, 8'h00);
    check("reset_data", {4'h0, dout}, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // Write then read with dummy nibbles.
    do_write(24'h000010, 32'hA53C_0000, 2);
    do_read(24'h000010, 2);

    // Address wrap.
    do_write(24'h00FFFF, 32'h1100_0000, 1);
    do_write(24'h000000, 32'h2200_0000, 1);
    do_read(24'h00FFFF, 2);

    // Unsupported command: oe stays low, array unchanged.
    cs_begin();
    nib(4'h9, 1'b0, 4'h0);
    nib(4'hF, 1'b0, 4'h0);
    repeat (8) nib(4'($urandom), 1'b0, 4'h0);
    cs_end();
    do_read(24'h000010, 2);

    // Abort a write after its first data nibble.
    do_write(24'h000004, 32'h5A00_0000, 1);
    cs_begin();
    hdr(8'h02, 24'h000004);
    nib(4'hF, 1'b0, 4'h0);
    cs_end();
    do_read(24'h000004, 1);

    // Reset during RD after the first data nibble.
    cs_begin();
    hdr(8'h03, 24'h000010);
    repeat (DUMMY_NIB) nib(4'($urandom), 1'b0, 4'h0);
    b = mget(16);
    nib(4'($urandom), 1'b1, b[7:4]);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rd_oe", {7'd0, oe}, 8'h00);
    check("rst_mid_rd_data", {4'h0, dout}, 8'h00);
    cs  = 1'b1;
    sck = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    do_read(24'h000010, 2);

    // Random writes with full 24-bit addresses, and reads of previously written ranges.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 0 || wr_addr_q.size() == 0) begin
        ra = 24'($urandom);
        rb = $urandom;
        n  = $urandom_range(1, 4);
        do_write(ra, rb, n);
      end else begin
        k = $urandom_range(0, wr_addr_q.size() - 1);
        do_read(24'($urandom_range(0, 255) << ADDR_W) | 24'(wr_addr_q[k]), wr_len_q[k]);
      end
    end
    if (!WR_EN) do_read(24'h000010, 1);

    tick(4);
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
